dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Responder (memory side) of the core's data-memory interface: addr/wdata/wmask/wen from the execute unit in, rdata and ack back.
- Replaces the zero-latency always-ack data SRAM hookup with a word-organised store that has a configurable wait-state count, byte-lane write masking and a one-cycle ack pulse per request.
- Lets the execute unit's ack/hold path run against real latency.

Parameters:
- ADDR_WIDTH, 10, word-address bits; depth = 2**ADDR_WIDTH 32-bit words.
- WAIT_CYCLES, 2, wait states between request capture and the access edge; legal range 0..15.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- req_i  input  1  request valid; held by requester until ack_o is seen.
- we_i  input  1  1 = write, 0 = read.
- addr_i  input  32  byte address; word index = addr_i[ADDR_WIDTH+1:2]; addr_i[1:0] ignored.
- wdata_i  input  32  write data, already lane-aligned.
- wmask_i  input  4  byte-lane write enables; bit i covers wdata_i[8i+7:8i].
- rdata_o  output  32  read data, valid while ack_o=1 for a read.
- ack_o  output  1  one-cycle completion pulse.
- err_o  output  1  range error flag, qualified by ack_o (see Optional Feature).

Behaviour:
- Clock/reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: state=IDLE, cnt=0, ack_o=0, rdata_o=0, err_o=0. Memory array is not cleared.
- FSM states:
  - IDLE: if req_i=1, capture we_i, addr_i, wdata_i and wmask_i into internal registers; cnt<=WAIT_CYCLES; go to WAIT.
  - WAIT, cnt!=0: cnt<=cnt-1; stay in WAIT.
  - WAIT, cnt==0 (access edge): perform the access; ack_o<=1; go to RESP.
  - RESP: ack_o<=0; err_o<=0; go to IDLE.
- req_i is sampled only in IDLE; changes to req_i and the other request inputs in WAIT/RESP are ignored.
- Latency: request sampled at edge E0, ack_o high in the cycle following edge E0+WAIT_CYCLES+1. Minimum request-to-ack is 2 cycles.
- Throughput: a continuously held req_i yields one ack every WAIT_CYCLES+3 cycles.
- Write: at the access edge, each byte lane with wmask=1 is updated; other lanes are kept.
  - wmask=0000 changes nothing but still acks.
  - rdata_o is unchanged by writes.
- Read: at the access edge, rdata_o<=full stored word. rdata_o holds that value until the next read access or reset.
- Read-after-write to the same word returns the merged new data, with no hazard window.
- Reset mid-operation (rst=1 in WAIT or RESP):
  - Next state is IDLE, ack_o=0.
  - A pending write whose access edge coincides with or follows rst is dropped; memory is untouched.
- rst together with req_i in IDLE: reset wins and the request is not captured.

Optional Feature:
- Macro: DMEM_RANGE_CHK_EN.
- Defined:
  - At capture, compute out-of-range = (addr_i[31:ADDR_WIDTH+2] != 0).
  - Out-of-range at the access edge: no write, rdata_o<=0, err_o<=1 together with ack_o. Same latency as a normal access.
  - err_o clears with ack_o.
- Undefined:
  - Upper address bits are ignored and addresses alias modulo the depth.
  - err_o is tied to 0.

Test Plan (ADDR_WIDTH=10, WAIT_CYCLES=2):
1. Reset: rst=1 for 3 cycles with req_i toggling -> ack_o=0, rdata_o=0x00000000, err_o=0 throughout; no request captured.
2. Write/read: write 0xDEADBEEF to 0x010 with wmask=1111 -> ack 4 cycles after req sampled; then read 0x010 -> rdata_o=0xDEADBEEF while ack_o=1.
3. Byte mask: write wdata=0x0000AA00 to 0x010 with wmask=0010 -> subsequent read returns 0xDEADAAEF. A write with wmask=0000 acks and the word stays 0xDEADAAEF.
4. Latency/throughput: req_i held high for 20 cycles on reads -> ack_o pulses exactly 1 cycle wide, every 5 cycles; rdata_o stable between pulses.
5. Reset mid-op:
   - Preload 0x11111111 at 0x020.
   - Issue write 0x12345678 to 0x020 and assert rst during WAIT -> no ack.
   - Read 0x020 -> 0x11111111.
6. Range: read address 0x00001000.
   - With DMEM_RANGE_CHK_EN: ack with err_o=1, rdata_o=0; a write to 0x00001000 leaves word 0x000 unchanged.
   - Without the macro: the access aliases word 0x000 and err_o=0.

Source files
------------

// File: rtl/dmem_responder_if.sv
// ----------------------------------------------------------------------------
// dmem_responder_if
//
// Data-memory request/response bundle between the execute unit (master) and
// the data-memory responder (slave).
//
// Handshake: the master raises req_i with we_i/addr_i/wdata_i/wmask_i stable
// and holds req_i until it sees ack_o. The slave samples the request only
// while idle, and answers with exactly one single-cycle ack_o pulse per
// accepted request. rdata_o and err_o are meaningful only while ack_o=1
// (rdata_o additionally holds its last read value between reads).
//
// Signals:
//   req_i    request valid (master -> slave)
//   we_i     1 = write, 0 = read
//   addr_i   byte address
//   wdata_i  lane-aligned write data
//   wmask_i  byte-lane write enables
//   rdata_o  read data (slave -> master)
//   ack_o    one-cycle completion pulse
//   err_o    range error, qualified by ack_o
// ----------------------------------------------------------------------------
interface dmem_responder_if;
  logic        req_i;
  logic        we_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [3:0]  wmask_i;
  logic [31:0] rdata_o;
  logic        ack_o;
  logic        err_o;

  modport master (
    output req_i, we_i, addr_i, wdata_i, wmask_i,
    input  rdata_o, ack_o, err_o
  );

  modport slave (
    input  req_i, we_i, addr_i, wdata_i, wmask_i,
    output rdata_o, ack_o, err_o
  );
endinterface

// File: rtl/dmem_responder.sv
// ----------------------------------------------------------------------------
// dmem_responder
//
// Memory side of the core's data-memory interface. A word-organised store of
// 2**ADDR_WIDTH 32-bit words with WAIT_CYCLES wait states between request
// capture and the access edge, byte-lane write masking and a one-cycle ack
// pulse per request.
//
// Parameters:
//   ADDR_WIDTH   word-address bits (depth = 2**ADDR_WIDTH words)
//   WAIT_CYCLES  wait states, 0..15
//
// Ports:
//   clk      clock, rising edge
//   rst      synchronous active-high reset
//   bus      dmem_responder_if.slave (req/we/addr/wdata/wmask in,
//            rdata/ack/err out)
//   state_o  current FSM state (0=IDLE, 1=WAIT, 2=RESP) for observation
//
// Optional feature (macro DMEM_RANGE_CHK_EN):
//   defined   -> addresses with any bit set above the word index are flagged
//                at capture; such accesses do not write, return rdata=0 and
//                raise err_o together with ack_o.
//   undefined -> upper address bits are ignored (addresses alias modulo the
//                depth) and err_o is always 0.
//
// Timing: request sampled at edge E0 in IDLE; the access happens at edge
// E0+WAIT_CYCLES+1, so ack_o is high for the following cycle; one more edge
// returns to IDLE. A held request completes every WAIT_CYCLES+3 cycles.
// ----------------------------------------------------------------------------
module dmem_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  dmem_responder_if.slave       bus,
  output logic [1:0]            state_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;

  // Captured request
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            wmask_q, wmask_d;
  logic                  oor_q, oor_d;

  // Response registers
  logic                  ack_q, ack_d;
  logic                  err_q, err_d;
  logic [31:0]           rdata_q, rdata_d;

  // Storage; deliberately not cleared by reset
  logic [31:0]           mem_q [DEPTH];
  logic                  mem_we;

  // Out-of-range decode of the live request address
  logic                  oor_req;

`ifdef DMEM_RANGE_CHK_EN
  assign oor_req = |bus.addr_i[31:ADDR_WIDTH+2];
`else
  // Upper bits alias; the byte offset bits are never used either way.
  assign oor_req = 1'b0;
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.addr_i[31:ADDR_WIDTH+2], bus.addr_i[1:0]};
`endif

  // --------------------------------------------------------------------------
  // Next-state / output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    oor_d   = oor_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    rdata_d = rdata_q;
    mem_we  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.req_i) begin
          we_d    = bus.we_i;
          idx_d   = bus.addr_i[ADDR_WIDTH+1:2];
          wdata_d = bus.wdata_i;
          wmask_d = bus.wmask_i;
          oor_d   = oor_req;
          cnt_d   = WAIT_INIT;
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          // Access edge
          ack_d   = 1'b1;
          state_d = S_RESP;
          if (oor_q) begin
            rdata_d = 32'h0;
            err_d   = 1'b1;
          end else if (we_q) begin
            mem_we  = 1'b1;
          end else begin
            rdata_d = mem_q[idx_q];
          end
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State / response registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= 32'h0;
      wmask_q <= 4'h0;
      oor_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      oor_q   <= oor_d;
    end
  end

  // --------------------------------------------------------------------------
  // Storage write port. A write whose access edge coincides with reset is
  // dropped, so reset always leaves memory untouched.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      for (int b = 0; b < 4; b++) begin
        if (wmask_q[b]) begin
          mem_q[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
        end
      end
    end
  end

  assign bus.ack_o   = ack_q;
  assign bus.rdata_o = rdata_q;
  assign bus.err_o   = err_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_dmem_responder.sv
// ----------------------------------------------------------------------------
// tb_dmem_responder
//
// Directed bench for dmem_responder with ADDR_WIDTH=10, WAIT_CYCLES=2.
// Inputs are driven 1 time unit after a rising edge; outputs are sampled at
// the same point, away from the active edge.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dmem_responder;

  logic       clk;
  logic       rst;
  logic [1:0] state;
  int         checks;
  int         errors;

  dmem_responder_if bus();

  dmem_responder #(
    .ADDR_WIDTH  (10),
    .WAIT_CYCLES (2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus.slave),
    .state_o (state)
  );

  // --------------------------------------------------------------------------
  // Clock
  // --------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // --------------------------------------------------------------------------
  // Driver: issue one request, return when ack seen (or after a bound).
  // Request inputs are scrambled after capture; the responder must ignore
  // them. lat counts rising edges from (and including) the capture edge to
  // the edge that raises ack_o; -1 means no ack within the bound.
  // --------------------------------------------------------------------------
  task automatic do_access(input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] mask,
                           output logic [31:0] rd, output logic er,
                           output int lat, output logic ack_after,
                           output logic err_after);
    bus.we_i    = we;
    bus.addr_i  = addr;
    bus.wdata_i = wdata;
    bus.wmask_i = mask;
    bus.req_i   = 1'b1;
    lat = -1;
    rd  = 32'h0;
    er  = 1'b0;
    for (int n = 1; n <= 50; n++) begin
      @(posedge clk); #1;
      if (bus.ack_o) begin
        lat = n;
        rd  = bus.rdata_o;
        er  = bus.err_o;
        break;
      end
      if (n == 1) begin
        bus.we_i    = ~we;
        bus.addr_i  = ~addr;
        bus.wdata_i = ~wdata;
        bus.wmask_i = ~mask;
      end
    end
    bus.req_i = 1'b0;
    @(posedge clk); #1;
    ack_after = bus.ack_o;
    err_after = bus.err_o;
  endtask

  // --------------------------------------------------------------------------
  // 1. Reset with req_i toggling
  // --------------------------------------------------------------------------
  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      bus.req_i = (i % 2 == 0) ? 1'b0 : 1'b1;
      if (i == 2) bus.req_i = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (bus.ack_o !== 1'b0) begin
        errors++; $display("FAIL reset_ack cyc%0d got=%b exp=0", i, bus.ack_o);
      end
      checks++;
      if (bus.rdata_o !== 32'h0) begin
        errors++; $display("FAIL reset_rdata cyc%0d got=%h exp=00000000", i, bus.rdata_o);
      end
      checks++;
      if (bus.err_o !== 1'b0) begin
        errors++; $display("FAIL reset_err cyc%0d got=%b exp=0", i, bus.err_o);
      end
    end
    rst       = 1'b0;
    bus.req_i = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (state !== 2'd0) begin
      errors++; $display("FAIL reset_no_capture state got=%0d exp=0", state);
    end
    checks++;
    if (bus.ack_o !== 1'b0) begin
      errors++; $display("FAIL reset_post_ack got=%b exp=0", bus.ack_o);
    end
  endtask

  // --------------------------------------------------------------------------
  // 2. Full-word write then read
  // --------------------------------------------------------------------------
  task automatic test_write_read();
    logic [31:0] rd; logic er, aa, ea; int lat;
    do_access(1'b1, 32'h010, 32'hDEADBEEF, 4'hF, rd, er, lat, aa, ea);
    checks++;
    if (lat !== 4) begin
      errors++; $display("FAIL wr_latency got=%0d exp=4", lat);
    end
    checks++;
    if (aa !== 1'b0) begin
      errors++; $display("FAIL wr_ack_width got=%b exp=0", aa);
    end
    checks++;
    if (er !== 1'b0) begin
      errors++; $display("FAIL wr_err got=%b exp=0", er);
    end
    do_access(1'b0, 32'h010, 32'h0, 4'h0, rd, er, lat, aa, ea);
    checks++;
    if (rd !== 32'hDEADBEEF) begin
      errors++; $display("FAIL rd_data got=%h exp=deadbeef", rd);
    end
    checks++;
    if (lat !== 4) begin
      errors++; $display("FAIL rd_latency got=%0d exp=4", lat);
    end
    checks++;
    if (aa !== 1'b0) begin
      errors++; $display("FAIL rd_ack_width got=%b exp=0", aa);
    end
  endtask

  // --------------------------------------------------------------------------
  // 3. Byte-lane masking, including an empty mask
  // --------------------------------------------------------------------------
  task automatic test_byte_mask();
    logic [31:0] rd; logic er, aa, ea; int lat;
    do_access(1'b1, 32'h010, 32'h0000AA00, 4'b0010, rd, er, lat, aa, ea);
    do_access(1'b0, 32'h010, 32'h0, 4'h0, rd, er, lat, aa, ea);
    checks++;
    if (rd !== 32'hDEADAAEF) begin
      errors++; $display("FAIL mask_lane1 got=%h exp=deadaaef", rd);
    end
    do_access(1'b1, 32'h010, 32'hFFFFFFFF, 4'b0000, rd, er, lat, aa, ea);
    checks++;
    if (lat !== 4) begin
      errors++; $display("FAIL mask_zero_ack latency got=%0d exp=4", lat);
    end
    // A write must leave the last read data on rdata_o
    checks++;
    if (bus.rdata_o !== 32'hDEADAAEF) begin
      errors++; $display("FAIL wr_keeps_rdata got=%h exp=deadaaef", bus.rdata_o);
    end
    do_access(1'b0, 32'h010, 32'h0, 4'h0, rd, er, lat, aa, ea);
    checks++;
    if (rd !== 32'hDEADAAEF) begin
      errors++; $display("FAIL mask_zero_data got=%h exp=deadaaef", rd);
    end
  endtask

  // --------------------------------------------------------------------------
  // 4. Held request: one-cycle ack every 5 cycles, rdata stable
  // --------------------------------------------------------------------------
  task automatic test_back_to_back();
    logic exp_ack;
    bus.we_i    = 1'b0;
    bus.addr_i  = 32'h010;
    bus.wdata_i = 32'h0;
    bus.wmask_i = 4'h0;
    bus.req_i   = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      exp_ack = (i % 5 == 4);
      checks++;
      if (bus.ack_o !== exp_ack) begin
        errors++; $display("FAIL b2b_ack edge%0d got=%b exp=%b", i, bus.ack_o, exp_ack);
      end
      checks++;
      if (bus.rdata_o !== 32'hDEADAAEF) begin
        errors++; $display("FAIL b2b_rdata edge%0d got=%h exp=deadaaef", i, bus.rdata_o);
      end
    end
    bus.req_i = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (state !== 2'd0) begin
      errors++; $display("FAIL b2b_idle state got=%0d exp=0", state);
    end
  endtask

  // --------------------------------------------------------------------------
  // 5. Reset during WAIT and exactly on the access edge drops the write
  // --------------------------------------------------------------------------
  task automatic test_reset_mid_op();
    logic [31:0] rd; logic er, aa, ea; int lat;
    int rst_edge;
    do_access(1'b1, 32'h020, 32'h11111111, 4'hF, rd, er, lat, aa, ea);
    for (int k = 0; k < 2; k++) begin
      rst_edge = (k == 0) ? 2 : 4;
      bus.we_i    = 1'b1;
      bus.addr_i  = 32'h020;
      bus.wdata_i = 32'h12345678;
      bus.wmask_i = 4'hF;
      bus.req_i   = 1'b1;
      for (int n = 1; n < rst_edge; n++) begin
        @(posedge clk); #1;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst       = 1'b0;
      bus.req_i = 1'b0;
      checks++;
      if (state !== 2'd0) begin
        errors++; $display("FAIL midrst_state e%0d got=%0d exp=0", rst_edge, state);
      end
      checks++;
      if (bus.rdata_o !== 32'h0) begin
        errors++; $display("FAIL midrst_rdata e%0d got=%h exp=00000000", rst_edge, bus.rdata_o);
      end
      for (int n = 0; n < 6; n++) begin
        checks++;
        if (bus.ack_o !== 1'b0) begin
          errors++; $display("FAIL midrst_no_ack e%0d cyc%0d got=%b exp=0", rst_edge, n, bus.ack_o);
        end
        @(posedge clk); #1;
      end
      do_access(1'b0, 32'h020, 32'h0, 4'h0, rd, er, lat, aa, ea);
      checks++;
      if (rd !== 32'h11111111) begin
        errors++; $display("FAIL midrst_mem e%0d got=%h exp=11111111", rst_edge, rd);
      end
    end
  endtask

  // --------------------------------------------------------------------------
  // 6. Address above the array
  // --------------------------------------------------------------------------
  task automatic test_range();
    logic [31:0] rd; logic er, aa, ea; int lat;
    logic [31:0] exp_rd, exp_w0;
    logic        exp_er;
`ifdef DMEM_RANGE_CHK_EN
    exp_rd = 32'h0;
    exp_er = 1'b1;
    exp_w0 = 32'hCAFEF00D;
`else
    exp_rd = 32'hCAFEF00D;
    exp_er = 1'b0;
    exp_w0 = 32'h55555555;
`endif
    do_access(1'b1, 32'h000, 32'hCAFEF00D, 4'hF, rd, er, lat, aa, ea);
    do_access(1'b0, 32'h1000, 32'h0, 4'h0, rd, er, lat, aa, ea);
    checks++;
    if (rd !== exp_rd) begin
      errors++; $display("FAIL range_rd_data got=%h exp=%h", rd, exp_rd);
    end
    checks++;
    if (er !== exp_er) begin
      errors++; $display("FAIL range_rd_err got=%b exp=%b", er, exp_er);
    end
    checks++;
    if (lat !== 4) begin
      errors++; $display("FAIL range_latency got=%0d exp=4", lat);
    end
    checks++;
    if (ea !== 1'b0) begin
      errors++; $display("FAIL range_err_clear got=%b exp=0", ea);
    end
    do_access(1'b1, 32'h1000, 32'h55555555, 4'hF, rd, er, lat, aa, ea);
    checks++;
    if (er !== exp_er) begin
      errors++; $display("FAIL range_wr_err got=%b exp=%b", er, exp_er);
    end
    do_access(1'b0, 32'h000, 32'h0, 4'h0, rd, er, lat, aa, ea);
    checks++;
    if (rd !== exp_w0) begin
      errors++; $display("FAIL range_word0 got=%h exp=%h", rd, exp_w0);
    end
    checks++;
    if (er !== 1'b0) begin
      errors++; $display("FAIL range_word0_err got=%b exp=0", er);
    end
  endtask

  // --------------------------------------------------------------------------
  // Sequence and report
  // --------------------------------------------------------------------------
  initial begin
    checks      = 0;
    errors      = 0;
    rst         = 1'b1;
    bus.req_i   = 1'b0;
    bus.we_i    = 1'b0;
    bus.addr_i  = 32'h0;
    bus.wdata_i = 32'h0;
    bus.wmask_i = 4'h0;

    test_reset();
    test_write_read();
    test_byte_mask();
    test_back_to_back();
    test_reset_mid_op();
    test_range();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
